control_compuerta: RTL
======================

# control_compuerta

Shared-barrier scheduler for a single-lane parking gate used by both entering and exiting vehicles. It arbitrates between an entry request (raised once access/PIN validation succeeds) and an exit request. It sequences the barrier through open, vehicle-pass and close phases, and keeps the lot occupancy count. Entries are refused when the lot is full; exits are refused when it is empty.

## Interface
Parameters:
- CAPACIDAD, 8: maximum vehicles in the lot.
- ANCHO_OCUPACION, 4: occupancy counter width; CAPACIDAD ≤ 2^ANCHO_OCUPACION − 1.
- T_APERTURA, 100: cycles the gate stays open waiting for a pass before timing out; ≥ 1.
- T_CIERRE, 10: cycles the gate stays in the closing phase before the next grant; ≥ 1.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- sol_entrada  in  1  entry request, level, held by requester until granted.
- sol_salida  in  1  exit request, level, held until granted.
- sensor_paso  in  1  vehicle-past-barrier sensor, level.
- conc_entrada  out  1  entry grant, one-cycle pulse.
- conc_salida  out  1  exit grant, one-cycle pulse.
- senal_compuerta  out  1  barrier open command.
- ocupacion  out  ANCHO_OCUPACION  current vehicle count.
- lleno  out  1  ocupacion == CAPACIDAD.
- alarma_tiempo  out  1  one-cycle pulse on open timeout.

## Operation
- States: REPOSO, ABRIR_ENTRADA, ABRIR_SALIDA, CERRANDO.
- All outputs are registered. Reset values: state REPOSO, grants 0, senal_compuerta 0, ocupacion 0, lleno 0, alarma_tiempo 0, timer 0.
- Round-robin bit: reset value "last served = entry", so exit has priority first.
- Edge register for sensor_paso: reset value 1.

REPOSO:
- Entry is eligible when sol_entrada && !lleno.
- Exit is eligible when sol_salida && ocupacion != 0.
- If both are eligible, serve the one not served last, then update the round-robin bit.
- If neither is eligible, stay in REPOSO. Ineligible requests are not latched.

ABRIR_x:
- senal_compuerta = 1 throughout.
- conc_x = 1 only in the first cycle.
- The timer counts cycles from 0.
- Pass: sensor_paso = 1 while its registered previous value = 0. On a pass, ocupacion ±1 (entry +1, exit −1) and the state goes to CERRANDO.
- Timeout: no pass after T_APERTURA cycles. On timeout, pulse alarma_tiempo, leave ocupacion unchanged, and go to CERRANDO.
- If a pass and the timeout occur in the same cycle, the pass wins and no alarm is raised.
- Dropping the request mid-phase has no effect.

CERRANDO:
- senal_compuerta = 0.
- Hold exactly T_CIERRE cycles, then go to REPOSO.
- Requests and sensor edges are ignored.

Arithmetic and flags:
- Overflow and underflow are impossible by the eligibility rules; no saturation logic is needed.
- lleno is recomputed from the next value of ocupacion, so it updates in the same cycle as ocupacion.

## Timing
- Request eligible in REPOSO at cycle n → state ABRIR, conc_x = 1 and senal_compuerta = 1 at cycle n+1.
- Pass edge sampled at cycle k → at k+1: CERRANDO, senal_compuerta = 0, ocupacion/lleno updated.
- Timeout: first ABRIR cycle is t0 → at t0+T_APERTURA: CERRANDO and alarma_tiempo = 1 for one cycle.
- CERRANDO covers cycles c..c+T_CIERRE−1; REPOSO at c+T_CIERRE; earliest next grant at c+T_CIERRE+1.
- sensor_paso already high when ABRIR begins is not a pass; it must fall and rise again.
- Reset mid-operation (any state) → at the next cycle all outputs take reset values, with ocupacion 0 and gate closed.

## Structure
- Shared package acceso_pkg holds:
  - state encoding localparams (one-hot, 4 bits), matching the access controller's one-hot style;
  - default T_APERTURA and T_CIERRE.
- Timer width: $clog2(max(T_APERTURA, T_CIERRE) + 1).
- One sub-module: temporizador, a loadable up-counter with a terminal-count flag, shared by the ABRIR and CERRANDO phases. Clear it on every state change.
- Edge detection and the occupancy counter stay inline.

## Test plan
- Reset, then sol_entrada = 1 at n → conc_entrada and senal_compuerta high at n+1. sensor_paso 0→1 at n+4 → at n+5: ocupacion = 1, senal_compuerta = 0. senal_compuerta stays 0 for 10 cycles.
- Three entries, then sol_entrada and sol_salida both held → grants alternate exit, entry, exit, …. ocupacion goes 3→2→3→2. Each grant is separated by ≥ 11 idle-gate cycles.
- Eight entries → ocupacion = 8, lleno = 1.
  - A further sol_entrada gives no grant.
  - sol_salida is granted; after the pass, ocupacion = 7 and lleno = 0.
- Entry granted, sensor_paso held 0 → alarma_tiempo pulses exactly 100 cycles after the grant. ocupacion is unchanged and the gate closes.
- ocupacion = 0, sol_salida held 50 cycles → no conc_salida and senal_compuerta stays 0. sensor_paso high at grant time with no re-edge → times out, no count.
- reset asserted in the 3rd ABRIR_SALIDA cycle with ocupacion = 5 → next cycle: senal_compuerta = 0, ocupacion = 0, state REPOSO. No grant while reset is held.

Source files
------------

// File: rtl/acceso_pkg.sv
// Shared definitions for the parking access controllers.
// Contents:
//   - one-hot state codes for the gate scheduler (4 bits)
//   - default open-wait and closing durations, in clock cycles
//   - max_int helper used to size timers at elaboration time
package acceso_pkg;

    localparam logic [3:0] EST_REPOSO         = 4'b0001;
    localparam logic [3:0] EST_ABRIR_ENTRADA  = 4'b0010;
    localparam logic [3:0] EST_ABRIR_SALIDA   = 4'b0100;
    localparam logic [3:0] EST_CERRANDO       = 4'b1000;

    typedef enum logic [3:0] {
        REPOSO        = EST_REPOSO,
        ABRIR_ENTRADA = EST_ABRIR_ENTRADA,
        ABRIR_SALIDA  = EST_ABRIR_SALIDA,
        CERRANDO      = EST_CERRANDO
    } estado_t;

    localparam int T_APERTURA_DEF = 100;
    localparam int T_CIERRE_DEF   = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/temporizador.sv
// Loadable up-counter with terminal-count flag.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   cargar            load valor_carga into the counter this cycle
//   valor_carga       value loaded when cargar is high
//   limite            terminal count; the counter stops when it gets there
//   fin               high while the count equals limite
module temporizador #(
    parameter int ANCHO = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cargar,
    input  logic [ANCHO-1:0] valor_carga,
    input  logic [ANCHO-1:0] limite,
    output logic             fin
);

    logic [ANCHO-1:0] cuenta_q, cuenta_d;

    // Saturating at limite keeps the counter from wrapping while the
    // owner sits idle without reloading it.
    always_comb begin
        cuenta_d = cuenta_q;
        if (cargar) begin
            cuenta_d = valor_carga;
        end else if (cuenta_q != limite) begin
            cuenta_d = cuenta_q + ANCHO'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign fin = (cuenta_q == limite);

endmodule

// File: rtl/control_compuerta.sv
// Shared-barrier scheduler for a single-lane parking gate.
// Arbitrates entry/exit requests round-robin, sequences the barrier through
// open, vehicle-pass and close phases, and keeps the occupancy count.
//
// state         | meaning
// REPOSO        | gate closed, waiting for an eligible request
// ABRIR_ENTRADA | gate open for an entering vehicle, waiting for a pass
// ABRIR_SALIDA  | gate open for an exiting vehicle, waiting for a pass
// CERRANDO      | gate closing, requests and sensor ignored
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   sol_entrada       entry request (level, held until granted)
//   sol_salida        exit request (level, held until granted)
//   sensor_paso       vehicle-past-barrier sensor (level)
//   conc_entrada      entry grant, one-cycle pulse
//   conc_salida       exit grant, one-cycle pulse
//   senal_compuerta   barrier open command
//   ocupacion         current vehicle count
//   lleno             ocupacion == CAPACIDAD
//   alarma_tiempo     one-cycle pulse when the open phase times out
module control_compuerta
    import acceso_pkg::*;
#(
    parameter int CAPACIDAD       = 8,
    parameter int ANCHO_OCUPACION = 4,
    parameter int T_APERTURA      = T_APERTURA_DEF,
    parameter int T_CIERRE        = T_CIERRE_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sol_entrada,
    input  logic                       sol_salida,
    input  logic                       sensor_paso,
    output logic                       conc_entrada,
    output logic                       conc_salida,
    output logic                       senal_compuerta,
    output logic [ANCHO_OCUPACION-1:0] ocupacion,
    output logic                       lleno,
    output logic                       alarma_tiempo
);

    localparam int ANCHO_T = $clog2(max_int(T_APERTURA, T_CIERRE) + 1);

    estado_t                     estado_q, estado_d;
    logic                        ult_entrada_q, ult_entrada_d;
    logic                        sensor_prev_q;
    logic [ANCHO_OCUPACION-1:0]  ocupacion_q, ocupacion_d;
    logic                        lleno_q, lleno_d;
    logic                        conc_entrada_q, conc_entrada_d;
    logic                        conc_salida_q, conc_salida_d;
    logic                        senal_q, senal_d;
    logic                        alarma_q, alarma_d;

    logic                        pase;
    logic                        eleg_entrada, eleg_salida;
    logic                        t_cargar, t_fin;
    logic [ANCHO_T-1:0]          t_limite;

    assign pase         = sensor_paso && !sensor_prev_q;
    assign eleg_entrada = sol_entrada && !lleno_q;
    assign eleg_salida  = sol_salida && (ocupacion_q != '0);

    // The timer restarts from zero on every state change; fin marks the last
    // cycle of the current phase so the transition lands exactly on time.
    assign t_cargar = (estado_d != estado_q);

    always_comb begin
        t_limite = '0;
        case (estado_q)
            ABRIR_ENTRADA, ABRIR_SALIDA: t_limite = ANCHO_T'(T_APERTURA - 1);
            CERRANDO:                    t_limite = ANCHO_T'(T_CIERRE - 1);
            default:                     t_limite = '0;
        endcase
    end

    temporizador #(
        .ANCHO (ANCHO_T)
    ) u_temporizador (
        .clock       (clock),
        .reset       (reset),
        .cargar      (t_cargar),
        .valor_carga ('0),
        .limite      (t_limite),
        .fin         (t_fin)
    );

    always_comb begin
        estado_d       = estado_q;
        ult_entrada_d  = ult_entrada_q;
        ocupacion_d    = ocupacion_q;
        conc_entrada_d = 1'b0;
        conc_salida_d  = 1'b0;
        alarma_d       = 1'b0;

        unique case (estado_q)
            REPOSO: begin
                // With both eligible, serve whichever side was not served last.
                if (eleg_salida && (!eleg_entrada || ult_entrada_q)) begin
                    estado_d      = ABRIR_SALIDA;
                    conc_salida_d = 1'b1;
                    ult_entrada_d = 1'b0;
                end else if (eleg_entrada) begin
                    estado_d       = ABRIR_ENTRADA;
                    conc_entrada_d = 1'b1;
                    ult_entrada_d  = 1'b1;
                end
            end
            ABRIR_ENTRADA, ABRIR_SALIDA: begin
                // A pass in the timeout cycle wins over the alarm.
                if (pase) begin
                    estado_d = CERRANDO;
                    if (estado_q == ABRIR_ENTRADA) begin
                        ocupacion_d = ocupacion_q + ANCHO_OCUPACION'(1);
                    end else begin
                        ocupacion_d = ocupacion_q - ANCHO_OCUPACION'(1);
                    end
                end else if (t_fin) begin
                    estado_d = CERRANDO;
                    alarma_d = 1'b1;
                end
            end
            CERRANDO: begin
                if (t_fin) begin
                    estado_d = REPOSO;
                end
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        senal_d = (estado_d == ABRIR_ENTRADA) || (estado_d == ABRIR_SALIDA);
        lleno_d = (ocupacion_d == ANCHO_OCUPACION'(CAPACIDAD));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q       <= REPOSO;
            ult_entrada_q  <= 1'b1;
            sensor_prev_q  <= 1'b1;
            ocupacion_q    <= '0;
            lleno_q        <= 1'b0;
            conc_entrada_q <= 1'b0;
            conc_salida_q  <= 1'b0;
            senal_q        <= 1'b0;
            alarma_q       <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            ult_entrada_q  <= ult_entrada_d;
            sensor_prev_q  <= sensor_paso;
            ocupacion_q    <= ocupacion_d;
            lleno_q        <= lleno_d;
            conc_entrada_q <= conc_entrada_d;
            conc_salida_q  <= conc_salida_d;
            senal_q        <= senal_d;
            alarma_q       <= alarma_d;
        end
    end

    assign conc_entrada    = conc_entrada_q;
    assign conc_salida     = conc_salida_q;
    assign senal_compuerta = senal_q;
    assign ocupacion       = ocupacion_q;
    assign lleno           = lleno_q;
    assign alarma_tiempo   = alarma_q;

endmodule
